// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Purpose:
//   Serialises one byte per request onto an asynchronous UART line: a start
//   bit (0), eight data bits LSB first, an optional even-parity bit and one
//   stop bit (1). Every bit is held for exactly CLKS_PER_BIT clock cycles.
//   The line output is registered, so the first low cycle of a frame is the
//   cycle right after the edge that accepted the byte.
//
// Parameters:
//   CLKS_PER_BIT   clock cycles per serial bit, legal range 2..65535
//   PARITY_EN      1 inserts an even-parity bit between D7 and the stop bit
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   nRst           synchronous active-low reset
//   tx_ctrl        send request; the byte is taken while high in IDLE
//   tx_byte        byte to transmit, sampled only on the accept edge
//   tx_serial      registered UART line, idle high
//   transmit_ready high when a new byte can be accepted (IDLE)
//   tx_busy        high while a frame is in progress (not IDLE)
//   tx_done        one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       tx_ctrl,
    input  logic [7:0] tx_byte,
    output logic       tx_serial,
    output logic       transmit_ready,
    output logic       tx_busy,
    output logic       tx_done
);

    // The baud counter only has to reach CLKS_PER_BIT-1; keep at least one
    // bit so the smallest legal setting still produces a valid vector.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_reg_next;
    logic             tx_serial_next;
    logic             tx_done_next;

    logic             bit_end;
    logic             accept;

    // A bit period ends on the last count of the baud counter; every state
    // other than IDLE advances only on that boundary.
    assign bit_end = (baud_cnt == LAST_CNT);
    assign accept  = (state == IDLE) && tx_ctrl;

    // State register. Reset returns to IDLE regardless of where the frame
    // was, which is what aborts a frame cleanly.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. After D7 the parity state is visited only when the
    // parameter asks for it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tx_ctrl) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values. The baud counter is held at zero in IDLE so an
    // accepted byte always starts with a fresh bit period, and it wraps to
    // zero exactly on each boundary so no drift builds up over the frame.
    // The bit index only moves inside DATA and naturally wraps 7 -> 0 on the
    // way out. The shift register is written only on the accept edge, so the
    // byte on the line cannot change mid-frame.
    always_comb begin
        baud_cnt_next  = '0;
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;

        if (state != IDLE) begin
            if (!bit_end) begin
                baud_cnt_next = baud_cnt + CNT_W'(1);
            end
        end

        if (state == IDLE) begin
            bit_idx_next = 3'd0;
        end else if ((state == DATA) && bit_end) begin
            bit_idx_next = bit_idx + 3'd1;
        end

        if (accept) begin
            shift_reg_next = tx_byte;
        end
    end

    // Output logic. The line is registered, so its next value is derived
    // from the state being entered: the value appears on tx_serial in the
    // same cycle the new state becomes current. While entering DATA the
    // bit to send is selected with the bit index that will be current then.
    // tx_done fires on the STOP -> IDLE transition so it lands in the first
    // IDLE cycle.
    always_comb begin
        tx_serial_next = 1'b1;
        tx_done_next   = 1'b0;

        case (state_next)
            IDLE:    tx_serial_next = 1'b1;
            START:   tx_serial_next = 1'b0;
            DATA:    tx_serial_next = shift_reg[bit_idx_next];
            PARITY:  tx_serial_next = ^shift_reg;
            STOP:    tx_serial_next = 1'b1;
            default: tx_serial_next = 1'b1;
        endcase

        if ((state == STOP) && (state_next == IDLE)) begin
            tx_done_next = 1'b1;
        end
    end

    // Datapath and registered outputs. Reset clears everything to the idle
    // picture: line high, no completion pulse, counters and byte at zero.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
            tx_serial <= tx_serial_next;
            tx_done   <= tx_done_next;
        end
    end

    // Handshake flags come straight from the state register so the
    // upstream message logic sees them in the same cycle as the state.
    assign transmit_ready = (state == IDLE);
    assign tx_busy        = !transmit_ready;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Purpose:
//   Self-checking bench for uart_tx. Two instances share clock and reset:
//   one without parity and one with even parity, both at 4 clocks per bit.
//   Expected line waveforms are built from the frame format (start, data
//   LSB first, optional parity, stop, each repeated CLKS_PER_BIT times).
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       nRst;

    logic       ctrl0;
    logic [7:0] byte0;
    logic       ser0;
    logic       rdy0;
    logic       busy0;
    logic       done0;

    logic       ctrl1;
    logic [7:0] byte1;
    logic       ser1;
    logic       rdy1;
    logic       busy1;
    logic       done1;

    int         total = 0;
    int         bad   = 0;

    logic       exp_line[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (0)
    ) u_dut0 (
        .clk            (clk),
        .nRst           (nRst),
        .tx_ctrl        (ctrl0),
        .tx_byte        (byte0),
        .tx_serial      (ser0),
        .transmit_ready (rdy0),
        .tx_busy        (busy0),
        .tx_done        (done0)
    );

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (1)
    ) u_dut1 (
        .clk            (clk),
        .nRst           (nRst),
        .tx_ctrl        (ctrl1),
        .tx_byte        (byte1),
        .tx_serial      (ser1),
        .transmit_ready (rdy1),
        .tx_busy        (busy1),
        .tx_done        (done1)
    );

    // Reference frame: list of line levels, one entry per clock cycle.
    function automatic void build_frame(input logic [7:0] b, input bit par);
        logic bits[$];
        logic p;
        exp_line.delete();
        bits.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(((b >> i) & 8'h01) != 8'h00);
            p = p ^ (((b >> i) & 8'h01) != 8'h00);
        end
        if (par) bits.push_back(p);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int r = 0; r < CPB; r++) exp_line.push_back(bits[i]);
        end
    endfunction

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit par, input logic c, input logic [7:0] b);
        if (par) begin
            ctrl1 = c;
            byte1 = b;
        end else begin
            ctrl0 = c;
            byte0 = b;
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        drive(0, 1'b1, 8'($urandom));
        drive(1, 1'b1, 8'($urandom));
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (ser0 !== 1'b1 || rdy0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_outputs_dut0 cycle=%0d got ser=%b rdy=%b busy=%b done=%b want 1 1 0 0",
                         c, ser0, rdy0, busy0, done0);
            end
            total++;
            if (ser1 !== 1'b1 || rdy1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_outputs_dut1 cycle=%0d got ser=%b rdy=%b busy=%b done=%b want 1 1 0 0",
                         c, ser1, rdy1, busy1, done1);
            end
        end
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        tick();
        nRst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (ser0 !== 1'b1 || rdy0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_hold cycle=%0d got ser=%b rdy=%b busy=%b done=%b want 1 1 0 0",
                         c, ser0, rdy0, busy0, done0);
            end
        end
    endtask

    task automatic test_ctrl_at_release();
        logic [7:0] b;
        b = 8'($urandom);
        build_frame(b, 0);
        nRst = 1'b0;
        drive(0, 1'b1, b);
        tick();
        tick();
        nRst = 1'b1;
        tick();
        drive(0, 1'b0, 8'($urandom));
        for (int k = 1; k <= exp_line.size(); k++) begin
            total++;
            if (ser0 !== exp_line[k-1] || busy0 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL release_accept byte=%h cycle=%0d got ser=%b busy=%b want ser=%b busy=1",
                         b, k, ser0, busy0, exp_line[k-1]);
            end
            tick();
        end
        total++;
        if (done0 !== 1'b1 || rdy0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL release_done got done=%b rdy=%b want 1 1", done0, rdy0);
        end
        tick();
    endtask

    task automatic test_single_frame(input logic [7:0] b, input bit par);
        int   len;
        logic s, r, bz, d;
        build_frame(b, par);
        len = exp_line.size();
        drive(par, 1'b1, b);
        tick();
        drive(par, 1'b0, 8'($urandom));
        for (int k = 1; k <= len; k++) begin
            s  = par ? ser1  : ser0;
            r  = par ? rdy1  : rdy0;
            bz = par ? busy1 : busy0;
            d  = par ? done1 : done0;
            total++;
            if (s !== exp_line[k-1]) begin
                bad++;
                $display("[TB] FAIL frame_line par=%0d byte=%h cycle=%0d got=%b want=%b",
                         par, b, k, s, exp_line[k-1]);
            end
            total++;
            if (r !== 1'b0 || bz !== 1'b1 || d !== 1'b0) begin
                bad++;
                $display("[TB] FAIL frame_status par=%0d byte=%h cycle=%0d got rdy=%b busy=%b done=%b want 0 1 0",
                         par, b, k, r, bz, d);
            end
            tick();
        end
        s = par ? ser1 : ser0;
        r = par ? rdy1 : rdy0;
        d = par ? done1 : done0;
        total++;
        if (d !== 1'b1 || r !== 1'b1 || s !== 1'b1) begin
            bad++;
            $display("[TB] FAIL frame_done par=%0d byte=%h cycle=%0d got done=%b rdy=%b ser=%b want 1 1 1",
                     par, b, len + 1, d, r, s);
        end
        tick();
        d = par ? done1 : done0;
        total++;
        if (d !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_width par=%0d byte=%h got=%b want=0", par, b, d);
        end
    endtask

    task automatic test_ignore_busy();
        logic seq[$];
        build_frame(8'hA5, 0);
        seq = exp_line;
        seq.push_back(1'b1);
        build_frame(8'hFF, 0);
        foreach (exp_line[i]) seq.push_back(exp_line[i]);
        seq.push_back(1'b1);
        drive(0, 1'b1, 8'hA5);
        tick();
        drive(0, 1'b0, 8'h00);
        for (int c = 1; c <= 82; c++) begin
            if (c == 12) drive(0, 1'b1, 8'hFF);
            if (c == 42) drive(0, 1'b0, 8'h00);
            total++;
            if (ser0 !== seq[c-1]) begin
                bad++;
                $display("[TB] FAIL ignore_busy_line cycle=%0d got=%b want=%b", c, ser0, seq[c-1]);
            end
            total++;
            if (done0 !== ((c == 41) || (c == 82))) begin
                bad++;
                $display("[TB] FAIL ignore_busy_done cycle=%0d got=%b want=%b",
                         c, done0, ((c == 41) || (c == 82)));
            end
            tick();
        end
        total++;
        if (rdy0 !== 1'b1 || ser0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ignore_busy_end got rdy=%b ser=%b want 1 1", rdy0, ser0);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] b);
        logic seq[$];
        build_frame(b, 0);
        seq = exp_line;
        seq.push_back(1'b1);
        foreach (exp_line[i]) seq.push_back(exp_line[i]);
        seq.push_back(1'b1);
        drive(0, 1'b1, b);
        tick();
        for (int c = 1; c <= 82; c++) begin
            if (c == 50) drive(0, 1'b0, 8'h00);
            total++;
            if (ser0 !== seq[c-1]) begin
                bad++;
                $display("[TB] FAIL b2b_line byte=%h cycle=%0d got=%b want=%b", b, c, ser0, seq[c-1]);
            end
            total++;
            if (done0 !== ((c == 41) || (c == 82)) || rdy0 !== ((c == 41) || (c == 82))) begin
                bad++;
                $display("[TB] FAIL b2b_done byte=%h cycle=%0d got done=%b rdy=%b want %b",
                         b, c, done0, rdy0, ((c == 41) || (c == 82)));
            end
            tick();
        end
        total++;
        if (rdy0 !== 1'b1 || ser0 !== 1'b1 || done0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_end got rdy=%b ser=%b done=%b want 1 1 0", rdy0, ser0, done0);
        end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(8'h3C, 0);
        drive(0, 1'b1, 8'h3C);
        tick();
        drive(0, 1'b0, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            total++;
            if (ser0 !== exp_line[k-1]) begin
                bad++;
                $display("[TB] FAIL midreset_prefix cycle=%0d got=%b want=%b", k, ser0, exp_line[k-1]);
            end
            tick();
        end
        nRst = 1'b0;
        tick();
        total++;
        if (ser0 !== 1'b1 || done0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_abort got ser=%b done=%b rdy=%b busy=%b want 1 0 1 0",
                     ser0, done0, rdy0, busy0);
        end
        nRst = 1'b1;
        for (int c = 0; c < 45; c++) begin
            tick();
            total++;
            if (done0 !== 1'b0 || ser0 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL midreset_quiet cycle=%0d got done=%b ser=%b want 0 1", c, done0, ser0);
            end
        end
        test_single_frame(8'($urandom), 0);
    endtask

    initial begin
        nRst  = 1'b0;
        ctrl0 = 1'b0;
        byte0 = 8'h00;
        ctrl1 = 1'b0;
        byte1 = 8'h00;

        test_reset();
        test_ctrl_at_release();
        test_single_frame(8'h05, 0);
        for (int i = 0; i < 3; i++) test_single_frame(8'($urandom), 0);
        test_ignore_busy();
        test_back_to_back(8'h00);
        test_back_to_back(8'($urandom));
        test_reset_mid_frame();
        test_single_frame(8'h07, 1);
        test_single_frame(8'h03, 1);
        for (int i = 0; i < 3; i++) test_single_frame(8'($urandom), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 100; clock cycles per serial bit, legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0; when 1, an even-parity bit is inserted between D7 and the stop bit.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 nRst  input  1  reset, synchronous and active-low; sampled on rising edge of clk.
REQ-005 tx_ctrl  input  1  send request from message register; byte valid while high.
REQ-006 tx_byte  input  8  byte to transmit; sampled only on the accept cycle.
REQ-007 tx_serial  output  1  UART line to radio module; idle high.
REQ-008 transmit_ready  output  1  high when the block can accept a byte (IDLE only).
REQ-009 tx_busy  output  1  high while a frame is on the line (any state other than IDLE).
REQ-010 tx_done  output  1  single-cycle pulse marking frame completion.

Function
REQ-011 FSM states: IDLE, START, DATA, PARITY, STOP; encoding free.
REQ-012 Accept: in IDLE with tx_ctrl=1 at a rising edge, latch tx_byte into a shift register, enter START, clear baud counter and bit index.
REQ-013 In IDLE with tx_ctrl=0, hold state; tx_serial=1.
REQ-014 tx_serial is registered; it goes low in the first cycle after the accept edge (1-cycle latency).
REQ-015 START drives 0 for exactly CLKS_PER_BIT cycles, then enters DATA.
REQ-016 DATA drives bits LSB first (D0..D7), each for exactly CLKS_PER_BIT cycles; 3-bit index, after D7 go to PARITY if PARITY_EN=1 else STOP.
REQ-017 PARITY drives the XOR of the 8 latched bits (even parity) for CLKS_PER_BIT cycles, then STOP.
REQ-018 STOP drives 1 for exactly CLKS_PER_BIT cycles, then IDLE.
REQ-019 Baud counter is wide enough for CLKS_PER_BIT-1, counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary; no drift across a frame.
REQ-020 Frame length: 10*CLKS_PER_BIT cycles (11* with parity) from first low cycle to return to IDLE.
REQ-021 tx_done is high for exactly one cycle: the first cycle back in IDLE; transmit_ready is also high in that cycle.
REQ-022 transmit_ready = (state==IDLE); tx_busy = !transmit_ready; both combinational from state register.
REQ-023 tx_ctrl and tx_byte changes outside IDLE are ignored; the latched byte is never modified mid-frame.
REQ-024 Back-to-back: tx_ctrl held high produces a new START in the cycle after the tx_done cycle; inter-frame gap is exactly one high cycle.
REQ-025 tx_ctrl already high when reset releases is accepted on the first post-reset edge where state is IDLE.

Reset
REQ-026 nRst=0 at a rising edge forces state IDLE, tx_serial=1, tx_done=0, baud counter=0, bit index=0, shift register=0x00.
REQ-027 Reset mid-frame (any state) aborts the frame; tx_serial is 1 in the cycle after the reset edge; no tx_done pulse is generated.
REQ-028 During reset: transmit_ready=1, tx_busy=0.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-029 Reset: nRst low 2 cycles with tx_ctrl=1 -> tx_serial=1, transmit_ready=1, tx_busy=0, tx_done=0 throughout.
REQ-030 Single frame: tx_byte=0x05, tx_ctrl pulsed 1 cycle -> tx_serial sequence 0,1,0,1,0,0,0,0,0,1 each held 4 cycles, tx_done pulse at cycle 41 after accept, transmit_ready low for 40 cycles.
REQ-031 Ignore while busy: accept 0xA5, then change tx_byte to 0xFF with tx_ctrl=1 during DATA -> line still carries 0xA5 LSB first; 0xFF frame starts one cycle after tx_done.
REQ-032 Back-to-back: tx_ctrl held high, tx_byte=0x00 -> two frames separated by exactly one idle-high cycle; two tx_done pulses 41 cycles apart.
REQ-033 Reset mid-frame: assert nRst low during D3 of 0x3C -> tx_serial=1 next cycle, no tx_done, next accepted byte transmits a clean full frame.
REQ-034 Parity (PARITY_EN=1): 0x07 -> parity bit 1, 0x03 -> parity bit 0; frame 44 cycles, stop bit high 4 cycles.
